shift_reg_unit: RTL and testbench

- Multicycle barrel-replacement shifter for the MIPS datapath.
- Executes sll/srl/sra/sllv/srlv/srav (plus rotate-right) one bit position per clock.
- Its result feeds the writeback select as the shift-register source; the control FSM starts it and waits for done before writeback.

---
 rtl/shift_reg_unit.sv | 102 ++++++++++
 tb/tb_shift_reg_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/shift_reg_unit.sv
// Multicycle shifter for the MIPS datapath: SLL/SRL/SRA/ROR, one bit position per clock.
// Operands are captured on an accepted start; done pulses for one cycle with the result on data_out.
module shift_reg_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // The shift amount must be able to express every bit position of the operand.
    if ((2 ** SHAMT_W) < WIDTH) begin : g_bad_shamt_w
        $error("shift_reg_unit: SHAMT_W too narrow for WIDTH");
    end

    state_t             state;
    op_t                op_q;
    logic [SHAMT_W-1:0] count;

    // One single-bit step of the selected operation.
    function automatic logic [WIDTH-1:0] step_once(input logic [WIDTH-1:0] d, input op_t o);
        logic [WIDTH-1:0] r;
        r = d;
        unique case (o)
            OP_SLL: r = {d[WIDTH-2:0], 1'b0};
            OP_SRL: r = {1'b0, d[WIDTH-1:1]};
            OP_SRA: r = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROR: r = {d[0], d[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // NOTE: all state and outputs live in one clocked block with non-blocking
    // assignments, so busy/done are registered and change only with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            data_out <= '0;
            count    <= '0;
            op_q     <= OP_SLL;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_out <= data_in;
                        count    <= shamt;
                        op_q     <= op_t'(op);
                        busy     <= 1'b1;
                        if (shamt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_out <= step_once(data_out, op_q);
                    count    <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_unit.sv
// Self-checking bench for shift_reg_unit: directed cases plus randomized operations
// compared against an arithmetic reference model, including timing of busy/done.
module tb_shift_reg_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clk;
    logic               reset;
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   data_out;

    int checks = 0;
    int errors = 0;

    shift_reg_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Whole-amount result computed directly with shift operators.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int n);
        logic [31:0] r;
        case (o)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = $unsigned($signed(d) >>> n);
            default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
        return r;
    endfunction

    // Issue one operation at a negedge and follow it to completion.
    // inject_at > 0 pulses a conflicting start so that it is sampled at edge E<inject_at>.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] n,
                          input bit noisy, input int inject_at);
        logic [31:0] exp;
        int          k;
        bit          seen;
        exp     = model(o, d, int'(n));
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = n;
        @(negedge clk);
        start   = 1'b0;
        k       = 0;
        seen    = 1'b0;
        while (!seen) begin
            if (done) begin
                seen = 1'b1;
                check("done_latency", 32'(k), 32'(n));
                check("busy_at_done", 32'(busy), 32'd1);
                check("result", data_out, exp);
                start = 1'b0;
            end else begin
                check("busy_shift", 32'(busy), 32'd1);
                if (k > int'(n) + 2) begin
                    check("done_timeout", 32'(k), 32'(n));
                    start = 1'b0;
                    return;
                end
                if (k == inject_at - 1) begin
                    start   = 1'b1;
                    op      = 2'b01;
                    data_in = 32'hFFFF_FFFF;
                    shamt   = 5'd1;
                end else if (noisy) begin
                    start   = 1'($urandom_range(0, 1));
                    op      = 2'($urandom);
                    data_in = $urandom;
                    shamt   = 5'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", data_out, exp);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_d;
        logic [4:0]  r_n;
        logic [31:0] last;
        int          gap;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        shamt   = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_data_out", data_out, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_start", 32'(busy), 32'd0);

        run_op(2'b00, 32'h0000_0001, 5'd4, 1'b0, -1);
        run_op(2'b10, 32'h8000_0000, 5'd31, 1'b0, -1);
        run_op(2'b01, 32'h8000_0000, 5'd31, 1'b0, -1);
        run_op(2'b00, 32'hDEAD_BEEF, 5'd0, 1'b0, -1);
        run_op(2'b11, 32'h0000_0003, 5'd1, 1'b0, -1);
        run_op(2'b00, 32'h0000_0001, 5'd8, 1'b0, 3);

        // Reset in the middle of a shift: SLL 0xF by 10, reset after E5.
        start   = 1'b1;
        op      = 2'b00;
        data_in = 32'h0000_000F;
        shamt   = 5'd10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_data_out", data_out, 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midreset_no_done", 32'(done), 32'd0);
            check("midreset_idle", 32'(busy), 32'd0);
        end
        run_op(2'b00, 32'h0000_0001, 5'd2, 1'b0, -1);

        // Randomized operations with noisy inputs while busy and idle gaps between them.
        for (int t = 0; t < 150; t++) begin
            r_op = 2'($urandom);
            r_d  = $urandom;
            r_n  = 5'($urandom);
            run_op(r_op, r_d, r_n, 1'b1, -1);
            last = model(r_op, r_d, int'(r_n));
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                data_in = $urandom;
                @(negedge clk);
                check("idle_hold", data_out, last);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
